// File: rtl/encoder_spi_ctrl.sv
// encoder_spi_ctrl: SPI master that reads fixed-length frames from an absolute encoder.
module encoder_spi_ctrl #(
  parameter int CLK_DIV    = 100,
  parameter int FRAME_BITS = 24,
  parameter int GAP_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start,
  input  logic        miso,
  output logic        sck,
  output logic        cs_n,
  output logic [23:0] encoder_val_full,
  output logic [18:0] encoder_val,
  output logic        data_valid,
  output logic        busy,
  output logic        missed
);
  localparam int BW = $clog2(FRAME_BITS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic [9:0]      div_q, div_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [23:0]     shift_q, shift_d, full_q, full_d;
  logic            sck_q, sck_d, cs_n_q, cs_n_d, dv_q, dv_d, missed_q, missed_d;
  logic            div_end;
  logic [9:0]      div_nxt;

  assign div_end = div_q == 10'(CLK_DIV - 1);
  assign div_nxt = div_end ? '0 : div_q + 10'd1;

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    shift_d  = shift_q;
    full_d   = full_q;
    sck_d    = sck_q;
    cs_n_d   = cs_n_q;
    dv_d     = 1'b0;
    missed_d = missed_q | (start && state_q != IDLE);
    case (state_q)
      IDLE: if (start || enable) begin
        state_d = SETUP;
        cs_n_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
      end
      SETUP: begin
        div_d = div_nxt;
        if (div_end) state_d = SHIFT;
      end
      SHIFT: begin
        div_d = div_nxt;
        // sample miso on the same edge that raises sck
        if (div_end) begin
          sck_d = ~sck_q;
          if (!sck_q) begin
            shift_d = {shift_q[22:0], miso};
            bit_d   = bit_q + BW'(1);
          end else if (bit_q == BW'(FRAME_BITS)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        div_d = div_nxt;
        if (div_end) begin
          state_d = GAP;
          cs_n_d  = 1'b1;
          dv_d    = 1'b1;
          full_d  = shift_q;
          gap_d   = '0;
        end
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      shift_q  <= '0;
      full_q   <= '0;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      dv_q     <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shift_q  <= shift_d;
      full_q   <= full_d;
      sck_q    <= sck_d;
      cs_n_q   <= cs_n_d;
      dv_q     <= dv_d;
      missed_q <= missed_d;
    end
  end

  assign sck              = sck_q;
  assign cs_n             = cs_n_q;
  assign data_valid       = dv_q;
  assign missed           = missed_q;
  assign busy             = state_q != IDLE;
  assign encoder_val_full = full_q;
  assign encoder_val      = full_q[21:3];
endmodule
